pipelined_array_mult: RTL

Parametrised, pipelined unsigned/signed array multiplier. It is the sequential successor of the single-cycle mux-based multiplier array. Rows of partial-product/full-adder cells are grouped into register stages, and a valid/ready handshake on both sides supports backpressure. It sits between operand producers and the datapath consumer, sustaining one product per cycle when unstalled.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_row.sv | 45 ++++
 rtl/pipelined_array_mult.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the pipelined array multiplier.
// Latency: n/a (declarations only). Backpressure: n/a.
// Signed support is compiled in with MULT_SIGNED_EN.
package mult_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_RPS   = 2;

    function automatic int num_stages(input int width, input int rps);
        return width / rps;
    endfunction

    // Accept edge to out_valid: one input register, S array stages, one adder stage minus overlap.
    localparam int LATENCY = num_stages(DEF_WIDTH, DEF_RPS) + 1;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic [DEF_WIDTH-1:0] carry;
        logic [DEF_WIDTH-1:0] plow;
        logic [DEF_WIDTH-1:0] x;
        logic [DEF_WIDTH-1:0] y;
`ifdef MULT_SIGNED_EN
        logic                 tc;
`endif
        logic                 vld;
    } stage_reg_t;

endpackage

// File: rtl/mult_row.sv
// One carry-save row of WIDTH AND/full-adder cells; emits one finished product bit.
// Latency: combinational. Backpressure: none (pure logic).
// With MULT_SIGNED_EN, sgn applies Baugh-Wooley inversion and the 2^WIDTH correction.
module mult_row
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef MULT_SIGNED_EN
    , parameter int ROW = 0
`endif
) (
    input  logic [WIDTH-1:0] x,
    input  logic             yb,
`ifdef MULT_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] c_in,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] c_out,
    output logic             p_bit
);

    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] fs;
    logic             top;

`ifdef MULT_SIGNED_EN
    // MSB row inverts all but its top cell; every other row inverts only its top cell.
    localparam logic [WIDTH-1:0] INV = (ROW == WIDTH - 1) ?
        {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    assign pp  = (x & {WIDTH{yb}}) ^ (INV & {WIDTH{sgn}});
    // The free top slot after row 0 carries weight 2^WIDTH: the low correction constant.
    assign top = (ROW == 0) ? sgn : 1'b0;
`else
    assign pp  = x & {WIDTH{yb}};
    assign top = 1'b0;
`endif

    assign fs    = s_in ^ c_in ^ pp;
    assign c_out = (s_in & c_in) | (s_in & pp) | (c_in & pp);
    assign s_out = {top, fs[WIDTH-1:1]};
    assign p_bit = fs[0];

endmodule

// File: rtl/pipelined_array_mult.sv
// Pipelined carry-save array multiplier, ROWS_PER_STAGE rows per register stage (MULT_SIGNED_EN adds tc).
// Latency: WIDTH/ROWS_PER_STAGE + 1 cycles from accept to out_valid.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
module pipelined_array_mult
    import mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
`ifdef MULT_SIGNED_EN
    input  logic               tc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int S = num_stages(WIDTH, ROWS_PER_STAGE);

    if ((WIDTH < 2) || (WIDTH % ROWS_PER_STAGE != 0)) begin : g_bad_cfg
        $error("pipelined_array_mult: WIDTH must be >= 2 and divisible by ROWS_PER_STAGE");
    end

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] carry;
        logic [WIDTH-1:0] plow;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
`ifdef MULT_SIGNED_EN
        logic             tc;
`endif
        logic             vld;
    } stage_t;

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    stage_t in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
        end else if (!stall) begin
            in_q.sum   <= '0;
            in_q.carry <= '0;
            in_q.plow  <= '0;
            in_q.x     <= x;
            in_q.y     <= y;
`ifdef MULT_SIGNED_EN
            in_q.tc    <= tc;
`endif
            in_q.vld   <= in_valid;
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        stage_t cur;
        stage_t nxt;
        stage_t q;

        if (k == 0) begin : g_src_in
            assign cur = in_q;
        end else begin : g_src_prev
            assign cur = g_stage[k-1].q;
        end

        for (genvar r = 0; r < ROWS_PER_STAGE; r++) begin : g_row
            logic [WIDTH-1:0] s_i, c_i, pl_i;
            logic [WIDTH-1:0] s_o, c_o, pl_o;
            logic             pb;

            if (r == 0) begin : g_first
                assign s_i  = cur.sum;
                assign c_i  = cur.carry;
                assign pl_i = cur.plow;
            end else begin : g_chain
                assign s_i  = g_row[r-1].s_o;
                assign c_i  = g_row[r-1].c_o;
                assign pl_i = g_row[r-1].pl_o;
            end

            mult_row #(
                .WIDTH (WIDTH)
`ifdef MULT_SIGNED_EN
                , .ROW (k * ROWS_PER_STAGE + r)
`endif
            ) u_row (
                .x     (cur.x),
                .yb    (cur.y[r]),
`ifdef MULT_SIGNED_EN
                .sgn   (cur.tc),
`endif
                .s_in  (s_i),
                .c_in  (c_i),
                .s_out (s_o),
                .c_out (c_o),
                .p_bit (pb)
            );

            // Finished low product bits shift in from the top, landing in order after WIDTH rows.
            assign pl_o = {pb, pl_i[WIDTH-1:1]};
        end

        always_comb begin
            nxt       = cur;
            nxt.sum   = g_row[ROWS_PER_STAGE-1].s_o;
            nxt.carry = g_row[ROWS_PER_STAGE-1].c_o;
            nxt.plow  = g_row[ROWS_PER_STAGE-1].pl_o;
            nxt.y     = cur.y >> ROWS_PER_STAGE;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (!stall) begin
                q <= nxt;
            end
        end
    end

    stage_t           last;
    logic [WIDTH-1:0] hi;
    logic             out_vld_q;
    logic [2*WIDTH-1:0] p_q;

    assign last = g_stage[S-1].q;

    always_comb begin
        hi = last.sum + last.carry;
`ifdef MULT_SIGNED_EN
        // Adding 2^(2*WIDTH-1) modulo 2^(2*WIDTH) is a flip of the product MSB.
        hi[WIDTH-1] = hi[WIDTH-1] ^ last.tc;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            p_q       <= '0;
        end else if (!stall) begin
            out_vld_q <= last.vld;
            p_q       <= {hi, last.plow};
        end
    end

    assign out_valid = out_vld_q;
    assign p         = p_q;

    logic unused_tail;
    assign unused_tail = ^{last.x, last.y};

endmodule
